sram_access_arbiter: RTL
========================

// Module: sram_access_arbiter
// PURPOSE
//  Shares the single-port data SRAM between two requesters:
//   - port 0: the CPU datapath (load/store issued by control logic in T2/T3).
//   - port 1: a DMA/IO engine moving INPort data into SRAM.
//  Priority is fixed CPU-first, with a starvation guard that forces a DMA grant.
//  Sits between the requesters and the SRAM's Address/SRAMRead/SRAMWrite/Datain/Dataout.
// PARAMETERS
//  AW        8  address width (SRAM depth 2**AW)
//  DW        8  data width
//  MAX_WAIT  4  consecutive lost DMA arbitrations before DMA is forced to win (1..15)
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  Reset        in   1   asynchronous, active-low reset
//  cpu_req      in   1   CPU access request, held high until cpu_gnt
//  cpu_we       in   1   1=write, 0=read; valid with cpu_req
//  cpu_addr     in   AW  CPU address
//  cpu_wdata    in   DW  CPU write data
//  cpu_gnt      out  1   one-cycle pulse: CPU command is on the SRAM this cycle
//  cpu_rvalid   out  1   one-cycle pulse: cpu_rdata valid
//  cpu_rdata    out  DW  read data for CPU
//  cpu_stall    out  1   cpu_req & ~cpu_gnt (combinational); freezes TimingGen
//  dma_req/dma_we/dma_addr/dma_wdata        in   1/1/AW/DW   same rules as CPU
//  dma_gnt/dma_rvalid/dma_rdata             out  1/1/DW      same rules as CPU
//  SRAMAddress  out  AW  SRAM address
//  SRAMRead     out  1   SRAM read strobe
//  SRAMWrite    out  1   SRAM write strobe
//  SRAMDatain   out  DW  SRAM write data
//  SRAMDataout  in   DW  SRAM read data, valid the cycle after SRAMRead
// BEHAVIOUR
//  - Reset low: state=IDLE, wait_cnt=0, owner=CPU. All outputs 0 (cpu_stall follows cpu_req).
//  - Reset mid-access discards the access; no gnt/rvalid pulse is produced for it.
//  - FSM states:
//    - IDLE: sample requests; if any, latch winner's we/addr/wdata -> ISSUE, else stay.
//    - ISSUE (1 cycle): SRAM strobes and the winner's gnt driven from registers.
//      -> RESP if read, -> IDLE if write.
//    - RESP (1 cycle): winner's rvalid=1 and rdata=SRAMDataout; rdata holds until the next RESP.
//      -> IDLE.
//  - Latency from req sampled in IDLE:
//    - read: gnt at +1, rvalid at +2.
//    - write: gnt at +1.
//  - Throughput: write every 2 cycles, read every 3 cycles.
//  - Requests arriving in ISSUE/RESP are ignored until IDLE.
//    A requester drops req the cycle after gnt; a req still high in IDLE is a new access.
//  - Arbitration in IDLE:
//    - only one req: it wins.
//    - both req: DMA wins if wait_cnt==MAX_WAIT, else CPU wins.
//  - wait_cnt:
//    - +1 when DMA requests and loses (saturates at MAX_WAIT).
//    - cleared on DMA grant; unchanged when DMA is not requesting.
//  - SRAMRead and SRAMWrite are never both 1.
//  - SRAMAddress/SRAMDatain hold their last value outside ISSUE; strobes are 0.
//  - cpu_gnt and dma_gnt are never both 1; the same holds for the rvalids.
//  - Address and data pass through unmodified (no width conversion, no wrap).
// STRUCTURE
//  - Shared package risc_pkg:
//    - arb_state_t {IDLE=2'd0, ISSUE=2'd1, RESP=2'd2};
//    - owner encoding OWN_CPU=1'b0, OWN_DMA=1'b1;
//    - default MAX_WAIT.
//  - One sub-module arb_wait_counter: saturating 4-bit counter with inc, clr, limit, at_limit.
//  - Main module holds the FSM, the request latch and the output registers.
// TESTING
//  - Reset: Reset=0 during traffic -> all strobes/gnt/rvalid 0, state IDLE; release -> idle bus.
//  - CPU write: cpu_req=1, we=1, addr=8'h10, wdata=8'hA5 -> next cycle SRAMWrite=1,
//    SRAMAddress=8'h10, SRAMDatain=8'hA5, cpu_gnt=1; no rvalid.
//  - CPU read: SRAM[8'h10]=8'hA5, cpu read of 8'h10 -> gnt at +1, cpu_rvalid=1 with
//    cpu_rdata=8'hA5 at +2; dma_rvalid stays 0.
//  - Contention, MAX_WAIT=4: cpu_req and dma_req held continuously -> 4 CPU grants, then
//    1 DMA grant, pattern repeats; wait_cnt returns to 0 after each DMA grant.
//  - DMA alone: dma write 8'hFF->addr 8'h00, then read back -> dma_rdata=8'hFF, cpu_stall=0 throughout.
//  - Mid-access reset: Reset=0 during ISSUE of a read -> no rvalid pulse after release;
//    next CPU read completes normally.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg: shared types and defaults for the SRAM access arbiter.
package risc_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} arb_state_t;
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;
    localparam int DEFAULT_MAX_WAIT = 4;
endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: saturating 4-bit count of consecutive lost DMA arbitrations.
module arb_wait_counter (
    input  logic       clk,
    input  logic       Reset,
    input  logic       inc,
    input  logic       clr,
    input  logic [3:0] limit,
    output logic [3:0] count,
    output logic       atLimit
);
    assign atLimit = count >= limit;
    always_ff @(posedge clk or negedge Reset)
        if (!Reset) count <= '0;
        else if (clr) count <= '0;
        else if (inc && !atLimit) count <= count + 4'd1;
endmodule

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: shares one single-port SRAM between CPU and DMA,
// CPU-first with a starvation guard that forces a DMA grant.
module sram_access_arbiter
    import risc_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] SRAMAddress,
    output logic          SRAMRead,
    output logic          SRAMWrite,
    output logic [DW-1:0] SRAMDatain,
    input  logic [DW-1:0] SRAMDataout
);
    arb_state_t state, nextState;
    logic owner, latWe, dmaWins, anyReq, waitAtLimit;
    logic [3:0] waitCnt;
    logic [DW-1:0] cpuRdataQ, dmaRdataQ;

    arb_wait_counter uWait (
        .clk(clk),
        .Reset(Reset),
        .inc(state == IDLE && dma_req && !dmaWins),
        .clr(state == IDLE && dmaWins),
        .limit(4'(MAX_WAIT)),
        .count(waitCnt),
        .atLimit(waitAtLimit)
    );

    always_comb begin
        anyReq = cpu_req | dma_req;
        dmaWins = dma_req & (~cpu_req | waitAtLimit);
        nextState = state == IDLE ? (anyReq ? ISSUE : IDLE) :
                    state == ISSUE ? (latWe ? IDLE : RESP) : IDLE;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            owner <= OWN_CPU;
            latWe <= 1'b0;
            SRAMAddress <= '0;
            SRAMDatain <= '0;
            cpuRdataQ <= '0;
            dmaRdataQ <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && anyReq) begin
                owner <= dmaWins ? OWN_DMA : OWN_CPU;
                latWe <= dmaWins ? dma_we : cpu_we;
                SRAMAddress <= dmaWins ? dma_addr : cpu_addr;
                SRAMDatain <= dmaWins ? dma_wdata : cpu_wdata;
            end
            if (cpu_rvalid) cpuRdataQ <= SRAMDataout;
            if (dma_rvalid) dmaRdataQ <= SRAMDataout;
        end
    end

    // Read data is presented combinationally in RESP and held in a register afterwards.
    always_comb begin
        SRAMRead = state == ISSUE && !latWe;
        SRAMWrite = state == ISSUE && latWe;
        cpu_gnt = state == ISSUE && owner == OWN_CPU;
        dma_gnt = state == ISSUE && owner == OWN_DMA;
        cpu_rvalid = state == RESP && owner == OWN_CPU;
        dma_rvalid = state == RESP && owner == OWN_DMA;
        cpu_rdata = cpu_rvalid ? SRAMDataout : cpuRdataQ;
        dma_rdata = dma_rvalid ? SRAMDataout : dmaRdataQ;
        cpu_stall = cpu_req & ~cpu_gnt;
    end
endmodule
